// File: rtl/multi_edge_detector.sv
// Multi-channel synchroniser + debounce + edge detector with sticky flags and IRQ.
// Optional saturating per-channel edge counters: define MULTI_EDGE_DETECTOR_COUNT_EN.
module multi_edge_detector #(
   parameter int   NUM_CH          = 4,
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 1,
   parameter logic RESET_LEVEL     = 1'b0,
   parameter int   CNT_W           = 8
) (
   input  logic                    CLK,
   input  logic                    RSTN,
   input  logic [NUM_CH-1:0]       SAMPLE_IN,
   input  logic [NUM_CH-1:0]       STICKY_CLR_IN,
   input  logic [NUM_CH-1:0]       COUNT_CLR_IN,
   output logic [NUM_CH-1:0]       LEVEL_OUT,
   output logic [NUM_CH-1:0]       RISE_EDGE_OUT,
   output logic [NUM_CH-1:0]       FALL_EDGE_OUT,
   output logic [NUM_CH-1:0]       RISE_STICKY_OUT,
   output logic [NUM_CH-1:0]       FALL_STICKY_OUT,
   output logic                    IRQ_OUT,
   output logic [NUM_CH*CNT_W-1:0] EDGE_COUNT_OUT
);

   localparam int             DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [SYNC_STAGES-1:0] sync_reg;
         logic [DB_W-1:0]        db_cnt_reg;
         logic                   level_reg;
         logic                   prev_reg;
         logic                   rise_sticky_reg;
         logic                   fall_sticky_reg;
         logic                   sync_q;
         logic                   rise;
         logic                   fall;

         assign sync_q = sync_reg[SYNC_STAGES-1];
         assign rise   = level_reg & ~prev_reg;
         assign fall   = ~level_reg & prev_reg;

         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               sync_reg        <= {SYNC_STAGES{RESET_LEVEL}};
               db_cnt_reg      <= '0;
               level_reg       <= RESET_LEVEL;
               prev_reg        <= RESET_LEVEL;
               rise_sticky_reg <= 1'b0;
               fall_sticky_reg <= 1'b0;
            end else begin
               sync_reg <= {sync_reg[SYNC_STAGES-2:0], SAMPLE_IN[gi]};
               // Level only follows after DEBOUNCE_CYCLES consecutive differing samples.
               if (sync_q == level_reg) begin
                  db_cnt_reg <= '0;
               end else if (db_cnt_reg == DB_LAST) begin
                  level_reg  <= sync_q;
                  db_cnt_reg <= '0;
               end else begin
                  db_cnt_reg <= db_cnt_reg + DB_W'(1);
               end
               prev_reg        <= level_reg;
               rise_sticky_reg <= rise | (rise_sticky_reg & ~STICKY_CLR_IN[gi]);
               fall_sticky_reg <= fall | (fall_sticky_reg & ~STICKY_CLR_IN[gi]);
            end
         end

         assign LEVEL_OUT[gi]       = level_reg;
         assign RISE_EDGE_OUT[gi]   = rise;
         assign FALL_EDGE_OUT[gi]   = fall;
         assign RISE_STICKY_OUT[gi] = rise_sticky_reg;
         assign FALL_STICKY_OUT[gi] = fall_sticky_reg;

`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
         logic [CNT_W-1:0] cnt_reg;

         // A clear coinciding with an edge leaves the count at 1.
         always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
               cnt_reg <= '0;
            end else if (COUNT_CLR_IN[gi]) begin
               cnt_reg <= (rise | fall) ? CNT_W'(1) : '0;
            end else if ((rise | fall) && (cnt_reg != '1)) begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         assign EDGE_COUNT_OUT[gi*CNT_W +: CNT_W] = cnt_reg;
`else
         assign EDGE_COUNT_OUT[gi*CNT_W +: CNT_W] = '0;
`endif
      end
   endgenerate

`ifndef MULTI_EDGE_DETECTOR_COUNT_EN
   logic unused_count_clr;
   assign unused_count_clr = ^COUNT_CLR_IN;
`endif

   assign IRQ_OUT = |(RISE_STICKY_OUT | FALL_STICKY_OUT);

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed + randomised check of multi_edge_detector: instance A uses defaults,
// instance B uses DEBOUNCE_CYCLES=4, CNT_W=4; a windowed reference model tracks both.
module tb_multi_edge_detector;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]  in_a = 4'h0, sclr_a = 4'h0, cclr_a = 4'h0;
   logic [3:0]  in_b = 4'h0, sclr_b = 4'h0, cclr_b = 4'h0;
   logic [3:0]  lvl_a, rise_a, fall_a, rs_a, fs_a;
   logic [3:0]  lvl_b, rise_b, fall_b, rs_b, fs_b;
   logic        irq_a, irq_b;
   logic [31:0] cnt_a;
   logic [15:0] cnt_b;

   multi_edge_detector dut_a (
      .CLK(clk), .RSTN(rstn), .SAMPLE_IN(in_a), .STICKY_CLR_IN(sclr_a),
      .COUNT_CLR_IN(cclr_a), .LEVEL_OUT(lvl_a), .RISE_EDGE_OUT(rise_a),
      .FALL_EDGE_OUT(fall_a), .RISE_STICKY_OUT(rs_a), .FALL_STICKY_OUT(fs_a),
      .IRQ_OUT(irq_a), .EDGE_COUNT_OUT(cnt_a)
   );

   multi_edge_detector #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut_b (
      .CLK(clk), .RSTN(rstn), .SAMPLE_IN(in_b), .STICKY_CLR_IN(sclr_b),
      .COUNT_CLR_IN(cclr_b), .LEVEL_OUT(lvl_b), .RISE_EDGE_OUT(rise_b),
      .FALL_EDGE_OUT(fall_b), .RISE_STICKY_OUT(rs_b), .FALL_STICKY_OUT(fs_b),
      .IRQ_OUT(irq_b), .EDGE_COUNT_OUT(cnt_b)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model: a level bit follows the input once the last W synchronised
   // samples (input delayed by two edges) all agree.
   logic [3:0] hist [2][4096];
   logic [3:0] m_lvl [2];
   logic [3:0] m_prev [2];
   logic [3:0] m_rs [2];
   logic [3:0] m_fs [2];
   int         m_cnt [2][4];
   int         n;
   bit         model_on = 1'b0;

   task automatic model_reset();
      n = 0;
      for (int i = 0; i < 2; i++) begin
         m_lvl[i] = 4'h0; m_prev[i] = 4'h0; m_rs[i] = 4'h0; m_fs[i] = 4'h0;
         for (int c = 0; c < 4; c++) m_cnt[i][c] = 0;
      end
   endtask

   function automatic logic [3:0] hv(input int inst, input int k);
      if (k < 0) return 4'h0;
      return hist[inst][k % 4096];
   endfunction

   task automatic model_step(input int inst, input logic [3:0] din, input logic [3:0] sclr,
                             input logic [3:0] cclr, input int w, input int cmax);
      logic [3:0] rp, fp, nl, s;
      logic       v;
      bit         same;
      rp = m_lvl[inst] & ~m_prev[inst];
      fp = ~m_lvl[inst] & m_prev[inst];
      hist[inst][n % 4096] = din;
      m_rs[inst] = rp | (m_rs[inst] & ~sclr);
      m_fs[inst] = fp | (m_fs[inst] & ~sclr);
      for (int c = 0; c < 4; c++) begin
         if (cclr[c]) m_cnt[inst][c] = (rp[c] | fp[c]) ? 1 : 0;
         else if ((rp[c] | fp[c]) && m_cnt[inst][c] < cmax) m_cnt[inst][c]++;
      end
      nl = m_lvl[inst];
      for (int b = 0; b < 4; b++) begin
         s    = hv(inst, n - 2);
         v    = s[b];
         same = 1'b1;
         for (int j = 1; j < w; j++) begin
            s = hv(inst, n - 2 - j);
            if (s[b] != v) same = 1'b0;
         end
         if (same) nl[b] = v;
      end
      m_prev[inst] = m_lvl[inst];
      m_lvl[inst]  = nl;
   endtask

   function automatic logic [31:0] exp_cnt(input int inst, input int w);
      logic [31:0] r;
      r = 32'h0;
`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
      for (int c = 0; c < 4; c++) r = r | (32'(m_cnt[inst][c]) << (c * w));
`endif
      return r;
   endfunction

   task automatic compare_all();
      check("a_level",  32'(lvl_a),  32'(m_lvl[0]));
      check("a_rise",   32'(rise_a), 32'(m_lvl[0] & ~m_prev[0]));
      check("a_fall",   32'(fall_a), 32'(~m_lvl[0] & m_prev[0]));
      check("a_rstk",   32'(rs_a),   32'(m_rs[0]));
      check("a_fstk",   32'(fs_a),   32'(m_fs[0]));
      check("a_irq",    32'(irq_a),  32'(|(m_rs[0] | m_fs[0])));
      check("a_count",  cnt_a,       exp_cnt(0, 8));
      check("b_level",  32'(lvl_b),  32'(m_lvl[1]));
      check("b_rise",   32'(rise_b), 32'(m_lvl[1] & ~m_prev[1]));
      check("b_fall",   32'(fall_b), 32'(~m_lvl[1] & m_prev[1]));
      check("b_rstk",   32'(rs_b),   32'(m_rs[1]));
      check("b_fstk",   32'(fs_b),   32'(m_fs[1]));
      check("b_irq",    32'(irq_b),  32'(|(m_rs[1] | m_fs[1])));
      check("b_count",  32'(cnt_b),  exp_cnt(1, 4));
   endtask

   task automatic tick();
      @(posedge clk);
      if (model_on) begin
         model_step(0, in_a, sclr_a, cclr_a, 1, 255);
         model_step(1, in_b, sclr_b, cclr_b, 4, 15);
         n++;
      end
      #1;
      if (model_on) compare_all();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_lvl"},  32'({lvl_a, lvl_b}),   32'h0);
      check({tag, "_edge"}, 32'({rise_a, fall_a, rise_b, fall_b}), 32'h0);
      check({tag, "_stk"},  32'({rs_a, fs_a, rs_b, fs_b}), 32'h0);
      check({tag, "_irq"},  32'({irq_a, irq_b}),   32'h0);
      check({tag, "_cnt"},  cnt_a | 32'(cnt_b),     32'h0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rstn = 1'b1;
      model_reset();
      model_on = 1'b1;
   endtask

   logic [3:0] exp_sat;
   logic [3:0] exp_one;
   int         hold_a [4];
   int         hold_b [4];

   initial begin
`ifdef MULTI_EDGE_DETECTOR_COUNT_EN
      exp_sat = 4'hF;
      exp_one = 4'h1;
`else
      exp_sat = 4'h0;
      exp_one = 4'h0;
`endif
      // Reset with all inputs high, then release.
      in_a = 4'hF;
      repeat (2) @(posedge clk);
      #2;
      check_reset_values("rst");
      release_reset();
      $display("[TB] txn reset release, SAMPLE_IN=F");
      for (int t = 0; t < 4; t++) begin
         tick();
         if (t < 2) check("rel_lvl_early", 32'(lvl_a), 32'h0);
         if (t == 2) begin
            check("rel_lvl", 32'(lvl_a), 32'hF);
            check("rel_rise", 32'(rise_a), 32'hF);
            check("rel_irq_early", 32'(irq_a), 32'h0);
         end
         if (t == 3) begin
            check("rel_rise_done", 32'(rise_a), 32'h0);
            check("rel_rstk", 32'(rs_a), 32'hF);
            check("rel_irq", 32'(irq_a), 32'h1);
            check("rel_fall", 32'({fall_a, fs_a}), 32'h0);
         end
      end

      // Debounce: a 3-cycle glitch is rejected, a 4-cycle pulse passes.
      $display("[TB] txn debounce glitch 3 cycles on B ch0");
      for (int t = 0; t < 12; t++) begin
         in_b[0] = (t < 3);
         tick();
         check("glitch_lvl", 32'(lvl_b[0]), 32'h0);
         check("glitch_stk", 32'({rs_b[0], fs_b[0]}), 32'h0);
      end
      $display("[TB] txn debounce pulse 4 cycles on B ch0");
      for (int t = 0; t < 14; t++) begin
         in_b[0] = (t < 4);
         tick();
         check("pulse_lvl", 32'(lvl_b[0]), 32'((t >= 5) && (t <= 8)));
         check("pulse_rise", 32'(rise_b[0]), 32'(t == 5));
         check("pulse_fall", 32'(fall_b[0]), 32'(t == 9));
      end

      // Sticky clear coinciding with a rise: set wins; later clear drops IRQ.
      $display("[TB] txn sticky set-wins on A ch2");
      in_a[2] = 1'b0;
      repeat (6) tick();
      sclr_a = 4'hF;
      tick();
      sclr_a = 4'h0;
      in_a[2] = 1'b1;
      for (int t = 0; t < 6; t++) begin
         sclr_a = (t == 3 || t == 5) ? 4'b0100 : 4'b0000;
         tick();
         if (t == 2) check("sw_rise", 32'(rise_a), 32'h4);
         if (t == 3) check("sw_set_wins", 32'(rs_a), 32'h4);
         if (t == 4) check("sw_irq_set", 32'({rs_a, irq_a}), 32'h9);
         if (t == 5) check("sw_cleared", 32'({rs_a, fs_a, irq_a}), 32'h0);
      end
      sclr_a = 4'h0;

      // Async reset mid-operation while ch1 toggles every 8 cycles.
      $display("[TB] txn async reset mid-toggle on A ch1");
      for (int t = 0; t < 20; t++) begin
         if (t % 8 == 0) in_a[1] = ~in_a[1];
         tick();
      end
      #3;
      rstn = 1'b0;
      model_on = 1'b0;
      #1;
      check_reset_values("midrst");
      in_a = 4'h0;
      in_b = 4'h0;
      @(posedge clk);
      #1;
      check_reset_values("midrst_hold");
      release_reset();
      for (int t = 0; t < 8; t++) begin
         tick();
         check("post_rst_edges", 32'({rise_a, fall_a, rise_b, fall_b}), 32'h0);
      end

      // Counter: 20 edges on B ch3 saturate a 4-bit count; clear with edge gives 1.
      $display("[TB] txn counter saturation on B ch3");
      for (int e = 0; e < 20; e++) begin
         in_b[3] = ~in_b[3];
         repeat (5) tick();
      end
      repeat (6) tick();
      check("cnt_sat", 32'(cnt_b[15:12]), 32'(exp_sat));
      $display("[TB] txn counter clear with edge on B ch3");
      in_b[3] = ~in_b[3];
      for (int t = 0; t < 8; t++) begin
         cclr_b = (t == 6) ? 4'b1000 : 4'b0000;
         tick();
         if (t == 5) check("cnt_edge_rise", 32'(rise_b[3]), 32'h1);
         if (t == 6) check("cnt_clr_edge", 32'(cnt_b[15:12]), 32'(exp_one));
      end
      cclr_b = 4'h0;

      // Independent random toggles on every channel of both instances.
      for (int c = 0; c < 4; c++) begin
         hold_a[c] = $urandom_range(1, 12);
         hold_b[c] = $urandom_range(4, 12);
      end
      for (int blk = 0; blk < 10; blk++) begin
         $display("[TB] txn random block %0d", blk);
         for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < 4; c++) begin
               if (--hold_a[c] == 0) begin
                  in_a[c] = ~in_a[c];
                  hold_a[c] = $urandom_range(1, 12);
               end
               if (--hold_b[c] == 0) begin
                  in_b[c] = ~in_b[c];
                  hold_b[c] = $urandom_range(4, 12);
               end
            end
            sclr_a = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            sclr_b = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cclr_a = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            cclr_b = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
